// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory behind a valid/ready request
// channel and a valid/ready response channel. The FSM runs IDLE -> WAIT -> RESP.
// Stores write only the enabled byte lanes. Loads return the enabled lanes
// right-justified and either sign- or zero-extended. An illegal byte-enable
// pattern or an out-of-range word index is answered with an error and zero data.
module dmem_responder #(
    parameter int bitwidth    = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [bitwidth-1:0] req_addr,
    input  logic [bitwidth-1:0] req_wdata,
    input  logic [3:0]          req_byte_enable,
    input  logic                req_unsigned,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [bitwidth-1:0] rsp_rdata,
    output logic                rsp_error
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int WA_W  = bitwidth - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_r;
    logic [3:0]          cnt_r;
    logic                req_ready_r;
    logic                rsp_valid_r;
    logic [bitwidth-1:0] rsp_rdata_r;
    logic                rsp_error_r;

    // Request fields held for the duration of the wait states
    logic                write_r;
    logic [WA_W-1:0]     waddr_r;
    logic [31:0]         wdata_r;
    logic [3:0]          be_r;
    logic                unsigned_r;

    logic [31:0]         mem [DEPTH_WORDS];

    logic                accept_s;
    logic                do_access_s;
    logic                acc_write_s;
    logic [WA_W-1:0]     acc_waddr_s;
    logic [31:0]         acc_wdata_s;
    logic [3:0]          acc_be_s;
    logic                acc_unsigned_s;
    logic                acc_err_s;
    logic [31:0]         acc_word_s;
    logic [31:0]         acc_wword_s;
    logic [bitwidth-1:0] acc_rdata_s;
    logic                addr_lsb_unused_s;

    // The two low address bits only select a byte inside a word; the byte enables already carry that information.
    assign addr_lsb_unused_s = ^req_addr[1:0];

    // Only single bytes, aligned halfwords and full words are legal.
    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Replace only the enabled byte lanes of the old word.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = be[k] ? wdata[8*k +: 8] : old_word[8*k +: 8];
        end
        return res;
    endfunction

    // Right-justify the enabled lanes, then extend from bit 7 (byte) or bit 15 (halfword).
    function automatic logic [bitwidth-1:0] load_extract(input logic [31:0] word,
                                                         input logic [3:0]  be,
                                                         input logic        uns);
        logic [7:0]          b;
        logic [15:0]         h;
        logic [bitwidth-1:0] res;
        b = 8'h00;
        h = 16'h0000;
        case (be)
            4'b0001: b = word[7:0];
            4'b0010: b = word[15:8];
            4'b0100: b = word[23:16];
            4'b1000: b = word[31:24];
            4'b0011: h = word[15:0];
            4'b1100: h = word[31:16];
            default: begin
                b = 8'h00;
                h = 16'h0000;
            end
        endcase
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: res = {{(bitwidth-8){~uns & b[7]}}, b};
            4'b0011, 4'b1100:                   res = {{(bitwidth-16){~uns & h[15]}}, h};
            4'b1111:                            res = bitwidth'(word);
            default:                            res = '0;
        endcase
        return res;
    endfunction

    assign accept_s    = (state_r == S_IDLE) && req_valid && req_ready_r;
    assign do_access_s = ((state_r == S_WAIT) && (cnt_r <= 4'd1)) ||
                         ((state_r == S_IDLE) && accept_s && (WAIT_CYCLES == 0));

    // Choose the access operands. The live request is used when there are no wait states, the latched copy otherwise.
    always_comb begin
        if (state_r == S_IDLE) begin
            acc_write_s    = req_write;
            acc_waddr_s    = req_addr[bitwidth-1:2];
            acc_wdata_s    = req_wdata[31:0];
            acc_be_s       = req_byte_enable;
            acc_unsigned_s = req_unsigned;
        end else begin
            acc_write_s    = write_r;
            acc_waddr_s    = waddr_r;
            acc_wdata_s    = wdata_r;
            acc_be_s       = be_r;
            acc_unsigned_s = unsigned_r;
        end
        acc_err_s   = !be_legal(acc_be_s) || (acc_waddr_s >= WA_W'(DEPTH_WORDS));
        acc_word_s  = mem[acc_waddr_s[IDX_W-1:0]];
        acc_wword_s = store_merge(acc_word_s, acc_wdata_s, acc_be_s);
        if (acc_err_s || acc_write_s) begin
            acc_rdata_s = '0;
        end else begin
            acc_rdata_s = load_extract(acc_word_s, acc_be_s, acc_unsigned_s);
        end
    end

    // Storage array. It is not reset, and it is written only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (do_access_s && acc_write_s && !acc_err_s) begin
            mem[acc_waddr_s[IDX_W-1:0]] <= acc_wword_s;
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_error_r <= 1'b0;
            write_r     <= 1'b0;
            waddr_r     <= '0;
            wdata_r     <= 32'h0000_0000;
            be_r        <= 4'b0000;
            unsigned_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    req_ready_r <= 1'b1;
                    if (accept_s) begin
                        write_r     <= req_write;
                        waddr_r     <= req_addr[bitwidth-1:2];
                        wdata_r     <= req_wdata[31:0];
                        be_r        <= req_byte_enable;
                        unsigned_r  <= req_unsigned;
                        req_ready_r <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_r     <= S_RESP;
                            cnt_r       <= 4'd0;
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= acc_rdata_s;
                            rsp_error_r <= acc_err_s;
                        end else begin
                            state_r <= S_WAIT;
                            cnt_r   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_r <= 4'd1) begin
                        state_r     <= S_RESP;
                        cnt_r       <= 4'd0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= acc_rdata_s;
                        rsp_error_r <= acc_err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= S_IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= '0;
                        rsp_error_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    cnt_r       <= 4'd0;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= '0;
                    rsp_error_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_error = rsp_error_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byte_enable;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_responder #(
        .bitwidth    (32),
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_byte_enable (req_byte_enable),
        .req_unsigned    (req_unsigned),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete request with rsp_ready held high. Call it at #1 after a rising edge.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic uns,
                       output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        req_byte_enable = be; req_unsigned = uns; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_error;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_byte_enable = 4'h0; req_unsigned = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {31'd0, req_ready}, 32'd1);

        // Word store then load
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, rd, er, lat);
        check("st_word_rdata", rd, 32'h0);
        check("st_word_err", {31'd0, er}, 32'd0);
        check("st_word_lat", lat, 32'd3);
        txn(1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, rd, er, lat);
        check("ld_word_rdata", rd, 32'hDEADBEEF);
        check("ld_word_err", {31'd0, er}, 32'd0);
        check("ld_word_lat", lat, 32'd3);

        // Sign and zero extension
        txn(1'b1, 32'h10, 32'h80FF7F01, 4'b1111, 1'b0, rd, er, lat);
        txn(1'b0, 32'h10, 32'h0, 4'b0100, 1'b0, rd, er, lat);
        check("ld_b2_signed", rd, 32'hFFFFFFFF);
        txn(1'b0, 32'h10, 32'h0, 4'b1000, 1'b1, rd, er, lat);
        check("ld_b3_unsigned", rd, 32'h00000080);
        txn(1'b0, 32'h10, 32'h0, 4'b1100, 1'b0, rd, er, lat);
        check("ld_h1_signed", rd, 32'hFFFF80FF);
        txn(1'b0, 32'h10, 32'h0, 4'b1100, 1'b1, rd, er, lat);
        check("ld_h1_unsigned", rd, 32'h000080FF);
        txn(1'b0, 32'h10, 32'h0, 4'b0010, 1'b0, rd, er, lat);
        check("ld_b1_signed", rd, 32'h0000007F);
        txn(1'b0, 32'h10, 32'h0, 4'b0011, 1'b0, rd, er, lat);
        check("ld_h0_signed", rd, 32'h00007F01);
        txn(1'b0, 32'h10, 32'h0, 4'b1000, 1'b0, rd, er, lat);
        check("ld_b3_signed", rd, 32'hFFFFFF80);

        // Partial store
        txn(1'b1, 32'h10, 32'h11223344, 4'b1111, 1'b0, rd, er, lat);
        txn(1'b1, 32'h10, 32'hAAAABBCC, 4'b0011, 1'b0, rd, er, lat);
        txn(1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, rd, er, lat);
        check("partial_store", rd, 32'h1122BBCC);
        txn(1'b1, 32'h10, 32'h55667788, 4'b1000, 1'b0, rd, er, lat);
        txn(1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, rd, er, lat);
        check("byte3_store", rd, 32'h5522BBCC);
        txn(1'b1, 32'h10, 32'h11000000, 4'b1000, 1'b0, rd, er, lat);

        // Error cases
        txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0110, 1'b0, rd, er, lat);
        check("bad_be_err", {31'd0, er}, 32'd1);
        check("bad_be_rdata", rd, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, rd, er, lat);
        check("bad_be_mem", rd, 32'h1122BBCC);
        check("bad_be_next_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h400, 32'h0, 4'b1111, 1'b0, rd, er, lat);
        check("oob_ld_err", {31'd0, er}, 32'd1);
        check("oob_ld_rdata", rd, 32'h0);
        txn(1'b1, 32'h400, 32'h99999999, 4'b1111, 1'b0, rd, er, lat);
        check("oob_st_err", {31'd0, er}, 32'd1);
        txn(1'b0, 32'h3FC, 32'h0, 4'b0110, 1'b1, rd, er, lat);
        check("bad_be_ld_err", {31'd0, er}, 32'd1);

        // Backpressure on the response, with an ignored request during RESP
        txn(1'b1, 32'h30, 32'h12345678, 4'b1111, 1'b0, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_byte_enable = 4'b1111;
        req_unsigned = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wait_req_ready", {31'd0, req_ready}, 32'd0);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", lat, 32'd3);
        check("bp_rdata_first", rsp_rdata, 32'h1122BBCC);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'h1122BBCC);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_release_ready", {31'd0, req_ready}, 32'd1);
        txn(1'b0, 32'h30, 32'h0, 4'b1111, 1'b0, rd, er, lat);
        check("bp_ignored_store", rd, 32'h12345678);
        check("bp_next_lat", lat, 32'd3);

        // Abort on reset during WAIT
        txn(1'b1, 32'h20, 32'h00000000, 4'b1111, 1'b0, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        req_byte_enable = 4'b1111; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd0);
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", seen, 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'b1111, 1'b0, rd, er, lat);
        check("abort_mem", rd, 32'h00000000);
        check("abort_mem_lat", lat, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
